cache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate cache controller for the lab9 cache datapath.
- Sits between the CPU load/store port and the backing data memory: synchronous single-port-write RAM with a 1-cycle registered read.
- Holds tag/valid/data arrays in flops, sequences multi-word line fills from memory and forwards writes.
- One request is outstanding at a time.

---
 rtl/cache_pkg.sv | 43 ++++
 rtl/cache_ctrl_if.sv | 34 +++
 rtl/cache_store.sv | 50 +++++
 rtl/cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared parameters, address layout and FSM encoding for the direct-mapped,
// write-through cache controller.
package cache_pkg;

  localparam int unsigned CAPACITY   = 64;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned LINES      = 4;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned CNT_W      = 16;

  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned aw,
                                           input int unsigned lines,
                                           input int unsigned line_words);
    return aw - idx_bits(lines) - off_bits(line_words);
  endfunction

  localparam int unsigned AW = $clog2(CAPACITY);
  localparam int unsigned OW = off_bits(LINE_WORDS);
  localparam int unsigned IW = idx_bits(LINES);
  localparam int unsigned TW = tag_bits(AW, LINES, LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2
  } state_e;

  // Word address, LSB first: offset within line, line index, tag.
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [IW-1:0] idx;
    logic [OW-1:0] off;
  } addr_t;

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU request/response, backing-memory and statistics signals of the cache
// controller; slave is the controller side, master the CPU/memory side.
interface cache_ctrl_if;
  import cache_pkg::*;

  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [WIDTH-1:0]  cpu_wdata;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_rdata;
  logic              flush;
  logic              mem_we;
  logic [AW-1:0]     mem_w_addr;
  logic [AW-1:0]     mem_r_addr;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  mem_rd;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, flush, mem_rd,
    output cpu_ready, rsp_valid, rsp_rdata, mem_we, mem_w_addr, mem_r_addr,
           mem_wd, hit_count, miss_count
  );

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata, flush, mem_rd,
    input  cpu_ready, rsp_valid, rsp_rdata, mem_we, mem_w_addr, mem_r_addr,
           mem_wd, hit_count, miss_count
  );

endinterface

// File: rtl/cache_store.sv
// Tag, valid and data arrays of the cache. Lookup and read are combinational;
// word writes, tag/valid set and invalidation take effect at the clock edge.
module cache_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IW-1:0]    idx_i,
  input  logic [TW-1:0]    tag_i,
  input  logic [OW-1:0]    rd_off_i,
  output logic             hit_c_o,
  output logic [WIDTH-1:0] rd_data_c_o,
  input  logic             wr_en_i,
  input  logic [OW-1:0]    wr_off_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             line_set_i,
  input  logic             line_clr_i,
  input  logic             clear_all_i
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q  [LINES];
  logic [WIDTH-1:0] data_q [LINES][LINE_WORDS];

  assign hit_c_o     = valid_q[idx_i] && (tag_q[idx_i] == tag_i);
  assign rd_data_c_o = data_q[idx_i][rd_off_i];

  // Clear-all wins over single-line updates.
  always_comb begin
    valid_d = valid_q;
    if (clear_all_i) begin
      valid_d = '0;
    end else begin
      if (line_clr_i) valid_d[idx_i] = 1'b0;
      if (line_set_i) valid_d[idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (line_set_i) tag_q[idx_i] <= tag_i;
    if (wr_en_i)    data_q[idx_i][wr_off_i] <= wr_data_i;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller: request
// FSM, line-fill sequencing, memory write forwarding and hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.slave  bus
);

  localparam logic [1:0]     S_IDLE   = 2'(IDLE);
  localparam logic [1:0]     S_LOOKUP = 2'(LOOKUP);
  localparam logic [1:0]     S_FILL   = 2'(FILL);
  localparam int unsigned    CW       = OW + 1;
  localparam logic [OW-1:0]  LAST_OFF = OW'(LINE_WORDS - 1);
  localparam logic [CW-1:0]  FILL_END = CW'(LINE_WORDS);
  localparam logic [CW-1:0]  ISSUE_END = CW'(LINE_WORDS - 1);

  logic [1:0]       state_q, state_d;
  addr_t            addr_q, addr_d;
  logic             we_q, we_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_w_addr_q, mem_w_addr_d;
  logic [AW-1:0]    mem_r_addr_q, mem_r_addr_d;
  logic [WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic             st_hit;
  logic [WIDTH-1:0] st_rd_data;
  logic             st_wr_en;
  logic [OW-1:0]    st_wr_off;
  logic [WIDTH-1:0] st_wr_data;
  logic             st_line_set;
  logic             st_line_clr;
  logic             st_clear_all;

  cache_store u_store (
    .clk         (clk),
    .reset       (reset),
    .idx_i       (addr_q.idx),
    .tag_i       (addr_q.tag),
    .rd_off_i    (addr_q.off),
    .hit_c_o     (st_hit),
    .rd_data_c_o (st_rd_data),
    .wr_en_i     (st_wr_en),
    .wr_off_i    (st_wr_off),
    .wr_data_i   (st_wr_data),
    .line_set_i  (st_line_set),
    .line_clr_i  (st_line_clr),
    .clear_all_i (st_clear_all)
  );

  // Next-state, memory-side and response logic.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    fill_cnt_d   = fill_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    mem_we_d     = 1'b0;
    mem_w_addr_d = '0;
    mem_wd_d     = '0;
    mem_r_addr_d = '0;
    st_wr_en     = 1'b0;
    st_wr_off    = addr_q.off;
    st_wr_data   = wdata_q;
    st_line_set  = 1'b0;
    st_line_clr  = 1'b0;
    st_clear_all = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          st_clear_all = 1'b1;
        end else if (bus.cpu_valid) begin
          addr_d  = addr_t'(bus.cpu_addr);
          we_d    = bus.cpu_we;
          wdata_d = bus.cpu_wdata;
          // Store write-through is presented to memory during LOOKUP.
          if (bus.cpu_we) begin
            mem_we_d     = 1'b1;
            mem_w_addr_d = bus.cpu_addr;
            mem_wd_d     = bus.cpu_wdata;
          end
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (we_q) begin
          st_wr_en    = st_hit;
          rsp_valid_d = 1'b1;
          if (st_hit) hit_cnt_d  = hit_cnt_q + CNT_W'(1);
          else        miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d = S_IDLE;
        end else if (st_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = st_rd_data;
          hit_cnt_d   = hit_cnt_q + CNT_W'(1);
          state_d     = S_IDLE;
        end else begin
          miss_cnt_d   = miss_cnt_q + CNT_W'(1);
          st_line_clr  = 1'b1;
          fill_cnt_d   = '0;
          mem_r_addr_d = {addr_q.tag, addr_q.idx, OW'(0)};
          state_d      = S_FILL;
        end
      end

      S_FILL: begin
        // Word k is addressed in fill cycle k and captured in cycle k+1.
        if (fill_cnt_q != '0) begin
          st_wr_en   = 1'b1;
          st_wr_off  = OW'(fill_cnt_q - CW'(1));
          st_wr_data = bus.mem_rd;
        end
        if (fill_cnt_q < ISSUE_END) begin
          mem_r_addr_d = {addr_q.tag, addr_q.idx, OW'(fill_cnt_q + CW'(1))};
        end
        if (fill_cnt_q == FILL_END) begin
          st_line_set = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (addr_q.off == LAST_OFF) ? bus.mem_rd : st_rd_data;
          fill_cnt_d  = '0;
          state_d     = S_IDLE;
        end else begin
          fill_cnt_d = fill_cnt_q + CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      fill_cnt_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_w_addr_q <= '0;
      mem_r_addr_q <= '0;
      mem_wd_q     <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      fill_cnt_q   <= fill_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_w_addr_q <= mem_w_addr_d;
      mem_r_addr_q <= mem_r_addr_d;
      mem_wd_q     <= mem_wd_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Flush takes priority over a request presented in the same cycle.
  assign bus.cpu_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_w_addr = mem_w_addr_q;
  assign bus.mem_r_addr = mem_r_addr_q;
  assign bus.mem_wd     = mem_wd_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus randomized
// traffic compared against a line-level model of a direct-mapped cache.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk;
  logic reset;
  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: synchronous write, one-cycle registered read.
  logic [WIDTH-1:0] mem [CAPACITY];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_w_addr] <= bus.mem_wd;
    bus.mem_rd <= mem[bus.mem_r_addr];
  end

  // Reference model state.
  logic [WIDTH-1:0] ref_mem [CAPACITY];
  logic             ref_v   [LINES];
  int unsigned      ref_tag [LINES];
  int unsigned      ref_hits;
  int unsigned      ref_miss;

  int n_chk;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(LINES); i++) ref_v[i] = 1'b0;
    ref_hits = 0;
    ref_miss = 0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ":rsp_valid"},  32'(bus.rsp_valid),  32'd0);
    chk({nm, ":rsp_rdata"},  32'(bus.rsp_rdata),  32'd0);
    chk({nm, ":mem_we"},     32'(bus.mem_we),     32'd0);
    chk({nm, ":mem_w_addr"}, 32'(bus.mem_w_addr), 32'd0);
    chk({nm, ":mem_r_addr"}, 32'(bus.mem_r_addr), 32'd0);
    chk({nm, ":mem_wd"},     32'(bus.mem_wd),     32'd0);
    chk({nm, ":hit_count"},  32'(bus.hit_count),  32'd0);
    chk({nm, ":miss_count"}, 32'(bus.miss_count), 32'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.cpu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  // One request from acceptance to response, checked cycle by cycle.
  task automatic do_req(input string nm, input logic we, input int unsigned a,
                        input logic [WIDTH-1:0] d);
    int unsigned idx, tag, lat, n;
    logic hit, miss_load, got_rsp;
    logic [WIDTH-1:0] exp_rd;
    logic [AW-1:0] exp_ra, line_base;

    idx = (a / LINE_WORDS) % LINES;
    tag = a / (LINE_WORDS * LINES);
    hit = ref_v[idx] && (ref_tag[idx] == tag);
    miss_load = !we && !hit;
    line_base = AW'((a / LINE_WORDS) * LINE_WORDS);

    wait_ready();
    chk({nm, ":ready"}, 32'(bus.cpu_ready), 32'd1);
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = AW'(a);
    bus.cpu_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    if (we) begin
      ref_mem[a] = d;
      exp_rd = '0;
      lat = 2;
      if (hit) ref_hits++;
      else     ref_miss++;
    end else if (hit) begin
      exp_rd = ref_mem[a];
      lat = 2;
      ref_hits++;
    end else begin
      exp_rd = ref_mem[a];
      lat = LINE_WORDS + 3;
      ref_miss++;
      ref_v[idx]   = 1'b1;
      ref_tag[idx] = tag;
    end

    n = 1;
    got_rsp = 1'b0;
    while (n <= LINE_WORDS + 6) begin
      chk({nm, ":mem_we"}, 32'(bus.mem_we), 32'((n == 1) && we));
      if (n == 1 && we) begin
        chk({nm, ":mem_w_addr"}, 32'(bus.mem_w_addr), a);
        chk({nm, ":mem_wd"}, 32'(bus.mem_wd), 32'(d));
      end
      if (miss_load && n >= 2 && n <= LINE_WORDS + 1) exp_ra = line_base + AW'(n - 2);
      else exp_ra = '0;
      chk({nm, ":mem_r_addr"}, 32'(bus.mem_r_addr), 32'(exp_ra));
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
        break;
      end
      @(negedge clk);
      n++;
    end

    chk({nm, ":rsp_seen"}, 32'(got_rsp), 32'd1);
    if (got_rsp) begin
      chk({nm, ":latency"}, n, lat);
      chk({nm, ":rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
      chk({nm, ":ready_at_rsp"}, 32'(bus.cpu_ready), 32'd1);
    end
    chk({nm, ":hit_count"}, 32'(bus.hit_count), 32'(ref_hits % 65536));
    chk({nm, ":miss_count"}, 32'(bus.miss_count), 32'(ref_miss % 65536));
    @(negedge clk);
    chk({nm, ":rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  // Flush, optionally with a competing request in the same cycle.
  task automatic do_flush(input string nm, input logic with_req);
    wait_ready();
    bus.flush     = 1'b1;
    bus.cpu_valid = with_req;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = AW'($urandom_range(0, CAPACITY - 1));
    #1;
    chk({nm, ":ready_low"}, 32'(bus.cpu_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    for (int i = 0; i < int'(LINES); i++) ref_v[i] = 1'b0;
    #1;
    chk({nm, ":ready_after"}, 32'(bus.cpu_ready), 32'd1);
    chk({nm, ":no_rsp"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    int unsigned r, a, mem_diff;
    logic saw;
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.flush     = 1'b0;
    for (int i = 0; i < int'(CAPACITY); i++) begin
      mem[i]     = WIDTH'(32'h1000 + i);
      ref_mem[i] = WIDTH'(32'h1000 + i);
    end
    model_reset();

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset:ready", 32'(bus.cpu_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_req("t1_load05", 1'b0, 32'h05, '0);
    chk("t1_miss_is_1", 32'(bus.miss_count), 32'd1);
    do_req("t2_load06", 1'b0, 32'h06, '0);
    chk("t2_hit_is_1", 32'(bus.hit_count), 32'd1);
    do_req("t3_store06", 1'b1, 32'h06, 32'hDEADBEEF);
    do_req("t3_load06", 1'b0, 32'h06, '0);
    chk("t3_mem6", 32'(mem[6]), 32'hDEADBEEF);
    do_req("t4_load15", 1'b0, 32'h15, '0);
    do_req("t4_load05", 1'b0, 32'h05, '0);
    do_req("t5_store30", 1'b1, 32'h30, 32'h12345678);
    do_req("t5_load30", 1'b0, 32'h30, '0);
    do_flush("t6_flush", 1'b1);
    do_req("t6_load15", 1'b0, 32'h15, '0);

    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 23) : $urandom_range(0, CAPACITY - 1);
      if (r < 5) do_flush("rnd_flush", 1'(r % 2));
      else do_req("rnd", 1'($urandom_range(0, 3) == 0), a, WIDTH'($urandom()));
    end

    mem_diff = 0;
    for (int i = 0; i < int'(CAPACITY); i++) if (mem[i] !== ref_mem[i]) mem_diff++;
    chk("mem_image_diffs", mem_diff, 32'd0);

    // Reset in the middle of a line fill drops the request silently.
    wait_ready();
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = AW'(32'h05);
    @(posedge clk);
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_outputs("t7_rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) saw = 1'b1;
    end
    chk("t7_no_rsp", 32'(saw), 32'd0);
    chk("t7_ready", 32'(bus.cpu_ready), 32'd1);
    do_req("t7_load05", 1'b0, 32'h05, '0);
    chk("t7_miss_is_1", 32'(bus.miss_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
